// File: rtl/mem_map_pkg.sv
// Shared constants and types for the core-side memory responder: state encoding,
// default GPIO addresses and the bus widths.
package mem_map_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] IO_OUT_ADDR_DEF = 32'h0000_1000;
    localparam logic [ADDR_W-1:0] IO_IN_ADDR_DEF  = 32'h0000_1004;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_WAIT = S_WAIT,
        ST_RESP = S_RESP
    } state_t;

    // Where rsp_rdata comes from after a response has been loaded.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'b00,
        SRC_RAM  = 2'b01,
        SRC_REG  = 2'b10
    } rsp_src_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/sp_ram_word.sv
// Single-port synchronous word RAM; registered read, read-during-write returns old data.
module sp_ram_word
    import mem_map_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle core: word RAM plus GPIO registers
// behind a valid/ready request and a fixed number of wait states.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int                DEPTH       = 256,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] IO_OUT_ADDR = IO_OUT_ADDR_DEF,
    parameter logic [ADDR_W-1:0] IO_IN_ADDR  = IO_IN_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DATA_W-1:0] gpio_out,
    input  logic [DATA_W-1:0] gpio_in
);

    localparam int              IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] RAM_BYTES = (ADDR_W+1)'(DEPTH) << 2;

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              accept, enter_resp;
    mem_req_t          lat_q, acc;

    logic              misaligned, hit_out, hit_in, hit_ram, dec_err;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_addr, idx_q;
    logic [DATA_W-1:0] ram_rdata;

    rsp_src_t          rsp_src_q;
    logic [DATA_W-1:0] rsp_reg_q;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    wait_d = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q <= 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the access executes on the accepting edge, so the
    // live request is decoded instead of the latched copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc = '{we: req_we, addr: req_addr, wdata: req_wdata};
        end else begin
            acc = lat_q;
        end
    end

    always_comb begin
        misaligned = (acc.addr[1:0] != 2'b00);
        hit_out    = !misaligned && (acc.addr == IO_OUT_ADDR);
        hit_in     = !misaligned && !hit_out && (acc.addr == IO_IN_ADDR);
        hit_ram    = !misaligned && !hit_out && !hit_in && ({1'b0, acc.addr} < RAM_BYTES);
        dec_err    = !(hit_out || hit_in || hit_ram);
    end

    // The RAM keeps re-reading the last accessed word so its output stays
    // stable as the response data until the next access.
    assign ram_addr = enter_resp ? acc.addr[IDX_W+1:2] : idx_q;
    assign ram_we   = enter_resp && acc.we && hit_ram;

    sp_ram_word #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (acc.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
            lat_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= ram_addr;
            if (accept) begin
                lat_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err   <= 1'b0;
            rsp_src_q <= SRC_ZERO;
            rsp_reg_q <= '0;
            gpio_out  <= '0;
        end else if (enter_resp) begin
            rsp_err <= dec_err;
            if (dec_err || acc.we) begin
                rsp_src_q <= SRC_ZERO;
            end else if (hit_ram) begin
                rsp_src_q <= SRC_RAM;
            end else begin
                rsp_src_q <= SRC_REG;
            end
            rsp_reg_q <= hit_out ? gpio_out : (hit_in ? gpio_in : '0);
            if (acc.we && hit_out) begin
                gpio_out <= acc.wdata;
            end
        end
    end

    always_comb begin
        case (rsp_src_q)
            SRC_RAM: rsp_rdata = ram_rdata;
            SRC_REG: rsp_rdata = rsp_reg_q;
            default: rsp_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (1, 0 and 3 wait states) driven with
// directed and random accesses, checked against a word-array reference model.
module tb_mem_responder;

    localparam int ND    = 3;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [ND-1:0] rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_err;
    logic [31:0]   req_addr [ND];
    logic [31:0]   req_wdata[ND];
    logic [31:0]   rsp_rdata[ND];
    logic [31:0]   gpio_out [ND];
    logic [31:0]   gpio_in  [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        mem_responder #(
            .DEPTH(DEPTH), .WAIT_CYCLES(W),
            .IO_OUT_ADDR(32'h0000_1000), .IO_IN_ADDR(32'h0000_1004)
        ) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
            .gpio_out(gpio_out[g]), .gpio_in(gpio_in[g])
        );
    end

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mmem   [ND][DEPTH];
    bit          mknown [ND][DEPTH];
    logic [31:0] mgpio  [ND];
    logic [31:0] pool   [8];

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One complete request/response on instance d, with the model updated first.
    task automatic access(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] gin, input string tag);
        logic [31:0] exp_rd;
        logic        exp_err;
        bit          rd_known;
        bit          seen;
        int          k;
        exp_rd = 32'h0; exp_err = 1'b0; rd_known = 1'b1;
        if (addr % 4 != 0) exp_err = 1'b1;
        else if (addr == 32'h1000) begin
            if (we) mgpio[d] = wdata; else exp_rd = mgpio[d];
        end else if (addr == 32'h1004) begin
            if (!we) exp_rd = gin;
        end else if (addr < DEPTH * 4) begin
            if (we) begin
                mmem[d][addr / 4]   = wdata;
                mknown[d][addr / 4] = 1'b1;
            end else begin
                exp_rd   = mmem[d][addr / 4];
                rd_known = mknown[d][addr / 4];
            end
        end else exp_err = 1'b1;

        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wdata; gpio_in[d] = gin;
        @(negedge clk);
        // scramble request fields after acceptance; they must be ignored
        req_valid[d] = 1'b0; req_we[d] = 1'($urandom);
        req_addr[d] = $urandom; req_wdata[d] = $urandom;
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            if (rsp_valid[d]) seen = 1'b1;
            else begin
                if (req_ready[d]) begin
                    check({tag, " ready low in wait"}, 32'(req_ready[d]), 32'd0);
                end
                @(negedge clk);
                k++;
            end
        end
        check({tag, " latency"}, 32'(k), 32'(wait_of(d)));
        if (seen) begin
            check({tag, " ready in resp"}, 32'(req_ready[d]), 32'd0);
            check({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
            if (rd_known) check({tag, " rdata"}, rsp_rdata[d], exp_rd);
            @(negedge clk);
            check({tag, " pulse"}, 32'(rsp_valid[d]), 32'd0);
            if (rd_known) check({tag, " rdata hold"}, rsp_rdata[d], exp_rd);
            check({tag, " gpio_out"}, gpio_out[d], mgpio[d]);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: a = 32'h1000;
            1: a = 32'h1004;
            2: begin
                a = 32'($urandom_range(0, 2047)) << 2;
                a[1:0] = 2'($urandom_range(1, 3));
            end
            3: a = 32'(DEPTH * 4) + (32'($urandom_range(0, 63)) << 2);
            default: a = pool[$urandom_range(0, 7)];
        endcase
        return a;
    endfunction

    int stray;

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; gpio_in[d] = '0; mgpio[d] = '0;
        end
        for (int i = 0; i < 8; i++) pool[i] = 32'(i * 4 + 32'h40);
        #12;
        for (int d = 0; d < ND; d++) begin
            check("reset ready", 32'(req_ready[d]), 32'd1);
            check("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("reset rdata", rsp_rdata[d], 32'd0);
            check("reset err", 32'(rsp_err[d]), 32'd0);
            check("reset gpio_out", gpio_out[d], 32'd0);
        end
        @(negedge clk);
        rst_n = '1;

        // store/load, GPIO and error handling on the 1-wait instance
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, "st10");
        access(0, 1'b0, 32'h10, 32'h0, 32'h0, "ld10");
        access(0, 1'b1, 32'h1000, 32'h0000_00A5, 32'h0, "st gpio");
        access(0, 1'b0, 32'h1004, 32'h0, 32'h1234_5678, "ld gpio_in");
        access(0, 1'b1, 32'h1004, 32'hFFFF_FFFF, 32'h0, "st gpio_in");
        access(0, 1'b0, 32'h1000, 32'h0, 32'h0, "ld gpio_out");
        access(0, 1'b1, 32'h12, 32'h1111_2222, 32'h0, "st misaligned");
        access(0, 1'b0, 32'h10, 32'h0, 32'h0, "ld10 after err");
        access(0, 1'b0, 32'(DEPTH * 4), 32'h0, 32'h0, "ld oob");
        access(0, 1'b0, 32'h10, 32'h0, 32'h0, "ld clears err");
        access(0, 1'b0, 32'h1006, 32'h0, 32'h0, "ld io misaligned");

        // zero wait: back-to-back loads with req_valid held high
        access(1, 1'b1, 32'h0, 32'h0BAD_F00D, 32'h0, "w0 st0");
        access(1, 1'b1, 32'h4, 32'h0C0F_FEE0, 32'h0, "w0 st4");
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0;
        @(negedge clk);
        check("b2b rsp0 valid", 32'(rsp_valid[1]), 32'd1);
        check("b2b rsp0 ready", 32'(req_ready[1]), 32'd0);
        check("b2b rsp0 rdata", rsp_rdata[1], 32'h0BAD_F00D);
        req_addr[1] = 32'h4;
        @(negedge clk);
        check("b2b idle ready", 32'(req_ready[1]), 32'd1);
        check("b2b idle valid", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("b2b rsp1 valid", 32'(rsp_valid[1]), 32'd1);
        check("b2b rsp1 ready", 32'(req_ready[1]), 32'd0);
        check("b2b rsp1 rdata", rsp_rdata[1], 32'h0C0F_FEE0);
        @(negedge clk);
        check("b2b end ready", 32'(req_ready[1]), 32'd1);

        // reset during the second wait cycle of a store on the 3-wait instance
        access(2, 1'b1, 32'h1000, 32'hCAFE_F00D, 32'h0, "w3 st gpio");
        access(2, 1'b1, 32'h20, 32'hAAAA_0000, 32'h0, "w3 st20");
        access(2, 1'b0, 32'h20, 32'h0, 32'h0, "w3 ld20");
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'h5555_5555;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("w3 ready low in wait", 32'(req_ready[2]), 32'd0);
        rst_n[2] = 1'b0;
        #1;
        check("mid rst ready", 32'(req_ready[2]), 32'd1);
        check("mid rst valid", 32'(rsp_valid[2]), 32'd0);
        check("mid rst rdata", rsp_rdata[2], 32'd0);
        check("mid rst err", 32'(rsp_err[2]), 32'd0);
        check("mid rst gpio_out", gpio_out[2], 32'd0);
        mgpio[2] = 32'h0;
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[2]) stray++;
        end
        check("no rsp after reset", 32'(stray), 32'd0);
        access(2, 1'b0, 32'h20, 32'h0, 32'h0, "w3 ld20 after rst");

        // random traffic on every instance
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 8; i++) access(d, 1'b1, pool[i], $urandom, 32'h0, "seed");
            for (int i = 0; i < 30; i++) begin
                access(d, 1'($urandom_range(0, 1)), pick_addr(), $urandom, $urandom, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
